// File: rtl/io_uart_pkg.sv
// io_uart shared definitions: register offsets,
// status bit positions and FSM state encodings.
package io_uart_pkg;

  localparam logic [7:0] REG_DATA   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;
  localparam logic [7:0] REG_CTRL   = 8'd2;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXVALID = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_FRAMING = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

endpackage

// File: rtl/io_uart_if.sv
// io_uart I/O bus bundle: decoded I/O strobes in,
// read data and tristate enable out.
interface io_uart_if;

  logic [7:0] busIn;
  logic [7:0] busOut;
  logic       busNOE;
  logic       ioSelect;
  logic [7:0] ioAddress;
  logic       ioNOE;
  logic       ioNWE;

  modport master (
    output busIn, ioSelect, ioAddress, ioNOE, ioNWE,
    input  busOut, busNOE
  );

  modport slave (
    input  busIn, ioSelect, ioAddress, ioNOE, ioNWE,
    output busOut, busNOE
  );

endinterface

// File: rtl/io_uart_fifo.sv
// io_uart TX FIFO: synchronous, power-of-two depth,
// extra pointer MSB separates full from empty.
module io_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = wrPtr == rdPtr;
  assign full   = (wrPtr[AW] != rdPtr[AW]) &&
                  (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  // a pop frees the head slot first, so push-on-full is legal then
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr[AW-1:0]];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
  end

  // pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART (DATA/STATUS/CTRL).
// Optional CTRL loopback register: IO_UART_LOOPBACK_EN.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'h10,
  parameter int         CLKS_PER_BIT  = 16,
  parameter int         TX_FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  io_uart_if.slave    bus,
  input  logic        i_rx,
  output logic        o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic hitData, hitStatus, hitCtrl;
  logic rdStrobe, wrStrobe;
  logic dataRd, statusRd, dataWr;
  logic loopback, rxIn;

  logic [7:0] fifoHead;
  logic       fifoFull, fifoEmpty, txPop, txEmpty;
  txState_t   txState;
  logic [CW-1:0] txCnt;
  logic [2:0] txBit;
  logic [7:0] txShift;

  logic       rxMeta, rxSync, rxPrev;
  rxState_t   rxState;
  logic [CW-1:0] rxCnt;
  logic [2:0] rxBit;
  logic [7:0] rxShift;
  logic       rxDone, rxStopOk;
  logic [7:0] rxHold;
  logic       rxValid, rxOverrun, framingErr;
  logic [7:0] status;

  assign rdStrobe  = !bus.ioNOE;
  assign wrStrobe  = !bus.ioNWE;
  assign hitData   = bus.ioSelect &&
                     bus.ioAddress == 8'(BASE_ADDR + REG_DATA);
  assign hitStatus = bus.ioSelect &&
                     bus.ioAddress == 8'(BASE_ADDR + REG_STATUS);
  assign dataRd    = hitData && rdStrobe;
  assign statusRd  = hitStatus && rdStrobe;
  assign dataWr    = hitData && wrStrobe;

`ifdef IO_UART_LOOPBACK_EN
  assign hitCtrl = bus.ioSelect &&
                   bus.ioAddress == 8'(BASE_ADDR + REG_CTRL);

  // CTRL bit0 selects internal loopback
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) loopback <= 1'b0;
    else if (hitCtrl && wrStrobe) loopback <= bus.busIn[0];
  end

  assign rxIn = loopback ? o_tx : i_rx;
`else
  assign hitCtrl  = 1'b0;
  assign loopback = 1'b0;
  assign rxIn     = i_rx;
`endif

  assign txEmpty = fifoEmpty && txState == TX_IDLE;

  always_comb begin
    status = '0;
    status[ST_TXFULL]  = fifoFull;
    status[ST_TXEMPTY] = txEmpty;
    status[ST_RXVALID] = rxValid;
    status[ST_OVERRUN] = rxOverrun;
    status[ST_FRAMING] = framingErr;
  end

  // read mux drives the shared bus only on a mapped read
  always_comb begin
    bus.busOut = '0;
    bus.busNOE = 1'b1;
    if (rdStrobe) begin
      unique case (1'b1)
        hitData: begin
          bus.busNOE = 1'b0;
          bus.busOut = rxHold;
        end
        hitStatus: begin
          bus.busNOE = 1'b0;
          bus.busOut = status;
        end
        hitCtrl: begin
          bus.busNOE = 1'b0;
          bus.busOut = {7'b0, loopback};
        end
        default: ;
      endcase
    end
  end

  io_uart_fifo #(
    .WIDTH(8),
    .DEPTH(TX_FIFO_DEPTH)
  ) txFifo (
    .clk  (i_clk),
    .rst  (i_reset),
    .push (dataWr),
    .pop  (txPop),
    .wdata(bus.busIn),
    .rdata(fifoHead),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  assign txPop = !fifoEmpty &&
                 (txState == TX_IDLE ||
                  (txState == TX_STOP && txCnt == BAUD_LAST));

  // serializer; o_tx follows the state one cycle later
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      o_tx    <= 1'b1;
    end else begin
      if (txState != TX_IDLE)
        txCnt <= (txCnt == BAUD_LAST) ? '0 : txCnt + 1'b1;
      unique case (txState)
        TX_IDLE: begin
          o_tx <= 1'b1;
          if (txPop) begin
            txShift <= fifoHead;
            txCnt   <= '0;
            txState <= TX_START;
          end
        end
        TX_START: begin
          o_tx <= 1'b0;
          if (txCnt == BAUD_LAST) begin
            txBit   <= '0;
            txState <= TX_DATA;
          end
        end
        TX_DATA: begin
          o_tx <= txShift[0];
          if (txCnt == BAUD_LAST) begin
            txShift <= txShift >> 1;
            txBit   <= txBit + 3'd1;
            if (txBit == 3'd7) txState <= TX_STOP;
          end
        end
        TX_STOP: begin
          o_tx <= 1'b1;
          if (txCnt == BAUD_LAST) begin
            if (txPop) begin
              txShift <= fifoHead;
              txState <= TX_START;
            end else begin
              txState <= TX_IDLE;
            end
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // two-flop synchronizer plus edge history
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rxIn;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  // deserializer; only a high-to-low edge arms a frame
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rxState  <= RX_IDLE;
      rxCnt    <= '0;
      rxBit    <= '0;
      rxShift  <= '0;
      rxDone   <= 1'b0;
      rxStopOk <= 1'b0;
    end else begin
      rxDone <= 1'b0;
      unique case (rxState)
        RX_IDLE: begin
          rxCnt <= '0;
          if (rxPrev && !rxSync) rxState <= RX_START;
        end
        RX_START: begin
          rxCnt <= rxCnt + 1'b1;
          if (rxCnt == BAUD_MID) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            rxState <= rxSync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rxCnt <= (rxCnt == BAUD_LAST) ? '0 : rxCnt + 1'b1;
          if (rxCnt == BAUD_LAST) begin
            rxShift <= {rxSync, rxShift[7:1]};
            rxBit   <= rxBit + 3'd1;
            if (rxBit == 3'd7) rxState <= RX_STOP;
          end
        end
        RX_STOP: begin
          rxCnt <= (rxCnt == BAUD_LAST) ? '0 : rxCnt + 1'b1;
          if (rxCnt == BAUD_LAST) begin
            rxDone   <= 1'b1;
            rxStopOk <= rxSync;
            rxState  <= RX_IDLE;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // holding register and sticky flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rxHold     <= '0;
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
      framingErr <= 1'b0;
    end else begin
      if (dataRd) rxValid <= 1'b0;
      if (statusRd) begin
        rxOverrun  <= 1'b0;
        framingErr <= 1'b0;
      end
      if (rxDone) begin
        if (!rxStopOk) begin
          framingErr <= 1'b1;
        end else if (!rxValid || dataRd) begin
          rxHold  <= rxShift;
          rxValid <= 1'b1;
        end else begin
          rxOverrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// io_uart bench: random TX bursts and RX frames
// checked against a frame-level model of the line.
module tb_io_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h11;
  localparam logic [7:0] A_CTRL = 8'h12;
  localparam int LOGN = 16384;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  logic txLog [LOGN];

  io_uart_if bus();

  io_uart #(
    .BASE_ADDR    (8'h10),
    .CLKS_PER_BIT (CPB),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus),
    .i_rx   (rx),
    .o_tx   (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) txLog[cyc] = tx;
  end

  task automatic expectEq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input logic [7:0] a,
                          input logic [7:0] d);
    bus.ioSelect  = 1'b1;
    bus.ioAddress = a;
    bus.busIn     = d;
    bus.ioNWE     = 1'b0;
    @(negedge clk);
    bus.ioSelect  = 1'b0;
    bus.ioNWE     = 1'b1;
  endtask

  task automatic busRead(input  logic [7:0] a,
                         output logic [8:0] r);
    bus.ioSelect  = 1'b1;
    bus.ioAddress = a;
    bus.ioNOE     = 1'b0;
    #1;
    r = {bus.busNOE, bus.busOut};
    @(negedge clk);
    bus.ioSelect  = 1'b0;
    bus.ioNOE     = 1'b1;
  endtask

  task automatic readExpect(input string tag,
                            input logic [7:0] a,
                            input logic [8:0] exp);
    logic [8:0] r;
    busRead(a, r);
    expectEq(tag, 64'(r), 64'(exp));
  endtask

  task automatic sendRx(input logic [7:0] b,
                        input logic stopBit);
    logic [9:0] fr;
    fr = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      idle(CPB);
    end
    rx = 1'b1;
  endtask

  // expected line level inside one frame
  function automatic logic frameBit(input logic [7:0] b,
                                    input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic txBurst(input logic [7:0] q[$]);
    int c0, m, base;
    logic [63:0] act, exp;
    logic [8:0] r;
    c0 = 0;
    for (int i = 0; i < q.size(); i++) begin
      busWrite(A_DATA, q[i]);
      if (i == 0) c0 = cyc;
    end
    busRead(A_STAT, r);
    expectEq("txFillStatus", 64'(r),
             (q.size() > DEPTH) ? 64'h001 : 64'h000);
    m = (q.size() > DEPTH + 1) ? DEPTH + 1 : q.size();
    while (cyc < c0 + 2 + FRAME * m + 4) @(negedge clk);
    expectEq("txLead", {txLog[c0], txLog[c0+1]}, 64'h3);
    for (int f = 0; f < m; f++) begin
      act = '0;
      exp = '0;
      base = c0 + 2 + FRAME * f;
      for (int k = 0; k < FRAME; k++) begin
        act[k] = txLog[base + k];
        exp[k] = frameBit(q[f], k);
      end
      expectEq("txFrame", act, exp);
    end
    base = c0 + 2 + FRAME * m;
    expectEq("txTail", {txLog[base], txLog[base+1],
             txLog[base+2]}, 64'h7);
    readExpect("txDoneStatus", A_STAT, 9'h002);
  endtask

  task automatic rxOne(input logic [7:0] b);
    sendRx(b, 1'b1);
    idle(4);
    readExpect("rxStatus", A_STAT, 9'h006);
    readExpect("rxData", A_DATA, {1'b0, b});
    readExpect("rxStatusAfter", A_STAT, 9'h002);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b1, b2;
    rst = 1'b1;
    rx  = 1'b1;
    bus.ioSelect  = 1'b0;
    bus.ioAddress = 8'h00;
    bus.busIn     = 8'h00;
    bus.ioNOE     = 1'b1;
    bus.ioNWE     = 1'b1;
    idle(2);
    #1;
    expectEq("rstTx", 64'(tx), 64'h1);
    expectEq("rstBus", 64'({bus.busNOE, bus.busOut}), 64'h100);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    readExpect("rstStatus", A_STAT, 9'h002);

    q = '{8'hA5};
    txBurst(q);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    txBurst(q);
    for (int t = 0; t < 4; t++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++)
        q.push_back(8'($urandom));
      txBurst(q);
    end

    rxOne(8'h3C);
    for (int t = 0; t < 5; t++) begin
      rxOne(8'($urandom));
      idle($urandom_range(0, 5));
    end

    b1 = 8'($urandom);
    b2 = ~b1;
    sendRx(b1, 1'b1);
    idle(2);
    sendRx(b2, 1'b1);
    idle(4);
    readExpect("ovrData", A_DATA, {1'b0, b1});
    readExpect("ovrStatus", A_STAT, 9'h00A);
    readExpect("ovrCleared", A_STAT, 9'h002);

    sendRx(8'($urandom), 1'b0);
    idle(4);
    readExpect("frmStatus", A_STAT, 9'h012);
    readExpect("frmCleared", A_STAT, 9'h002);

    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    readExpect("glitchStatus", A_STAT, 9'h002);

    readExpect("unmappedHi", 8'h13, 9'h100);
    readExpect("unmappedLo", 8'h0F, 9'h100);
    busWrite(A_STAT, 8'hFF);
    readExpect("statusWrIgnored", A_STAT, 9'h002);

`ifdef IO_UART_LOOPBACK_EN
    readExpect("ctrlReset", A_CTRL, 9'h000);
    busWrite(A_CTRL, 8'hFF);
    readExpect("ctrlRead", A_CTRL, 9'h001);
    busWrite(A_DATA, 8'h5A);
    idle(70);
    readExpect("loopData", A_DATA, 9'h05A);
    busWrite(A_CTRL, 8'h00);
`else
    readExpect("ctrlUnmapped", A_CTRL, 9'h100);
    busWrite(A_CTRL, 8'hFF);
    readExpect("ctrlWrIgnored", A_STAT, 9'h002);
`endif

    busWrite(A_DATA, 8'hA5);
    idle(10);
    expectEq("midFrameLow", 64'(tx), 64'h0);
    #1 rst = 1'b1;
    #1;
    expectEq("midFrameRst", 64'(tx), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    readExpect("postRstStatus", A_STAT, 9'h002);
    idle(FRAME);
    expectEq("postRstIdle", 64'(tx), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the I/O bus, directly downstream of the memory unit's I/O decode (ioSelect/ioAddress/ioNOE/ioNWE).
- Occupies the I/O address window and joins the shared tristate bus as one more driver with its own NOE.
- Contains a TX FIFO feeding a serializer, an RX deserializer, and a single-byte RX holding register, so software can poll status and move bytes.

Parameters:
BASE_ADDR, 8'h10, first I/O address of the register window (DATA=+0, STATUS=+1, CTRL=+2)
CLKS_PER_BIT, 16, i_clk cycles per UART bit; minimum 4
TX_FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2

Ports:
i_clk  in  1  system clock (CPU clock domain); all state changes on rising edge
i_reset  in  1  asynchronous, active-high reset
i_bus  in  8  shared data bus (write data)
o_bus  out  8  read data
o_busNOE  out  1  active-low output enable onto shared bus
i_ioSelect  in  1  I/O cycle in progress
i_ioAddress  in  8  I/O register address
i_ioNOE  in  1  active-low I/O read strobe
i_ioNWE  in  1  active-low I/O write strobe
i_rx  in  1  serial input (idle high, asynchronous)
o_tx  out  1  serial output (idle high)

Behaviour:
- Reset (async, active-high) values:
  - o_tx=1, o_busNOE=1, o_bus=0.
  - FIFO empty; TX FSM and RX FSM in IDLE.
  - rxValid=0, rxOverrun=0, framingErr=0.
  - RX synchronizer flops=1.
  - Reset mid-frame aborts immediately; o_tx returns high in the same cycle.
- Decode:
  - hit = i_ioSelect & (i_ioAddress == BASE_ADDR + n).
  - Read: o_busNOE=0 combinationally while hit & ~i_ioNOE. Otherwise o_busNOE=1 and o_bus=0.
  - Write: sampled on the rising i_clk edge while hit & ~i_ioNWE.
- DATA write (+0): byte pushed into the TX FIFO. If the FIFO is full, the write is silently dropped.
- DATA read (+0): o_bus = RX holding byte. On each rising edge with the read strobe active, rxValid is cleared.
- STATUS read (+1): o_bus = {3'b0, framingErr, rxOverrun, rxValid, txEmpty, txFull}.
  - txEmpty = FIFO empty AND TX FSM in IDLE.
  - rxOverrun and framingErr are sticky; both cleared on a rising edge with a STATUS read strobe active.
- STATUS write: ignored.
- Unmapped addresses: no response; o_busNOE stays 1.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on FIFO non-empty, pop the head into the shift register and go to START (o_tx=0).
  - Each state is held CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first.
  - STOP: o_tx=1.
  - STOP -> START directly (no idle gap) if the FIFO is non-empty at the end of STOP.
  - Latency: first start bit appears 2 cycles after the write edge.
- RX path: i_rx passes through a 2-flop synchronizer. RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: falling edge of the synchronized rx -> START.
  - START: sampled at CLKS_PER_BIT/2. If high, treated as a glitch -> IDLE.
  - DATA: 8 samples, one every CLKS_PER_BIT, each at bit centre.
  - STOP: sampled at centre.
    - Stop=1: byte loaded into holding; rxValid=1.
    - Stop=0: byte discarded; framingErr=1.
  - After STOP, return to IDLE and wait for rx high before arming.
- Simultaneous events:
  - FIFO push and pop in the same cycle: both happen, count unchanged. This is legal even when full, because the pop frees the slot first.
  - RX byte completes while rxValid=1 with no DATA read that cycle: new byte discarded, rxOverrun=1.
  - RX byte completes in the same cycle as a DATA read: new byte loaded, rxValid stays 1, no overrun.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - FIFO pointers are $clog2(TX_FIFO_DEPTH)+1 bits; full/empty are taken from the MSB compare.

Optional Feature:
IO_UART_LOOPBACK_EN
- Defined:
  - CTRL register at BASE_ADDR+2 is readable and writable; reset value 0.
  - CTRL bit0 = loopback. When 1, the RX synchronizer input is o_tx instead of i_rx, and o_tx still drives the pin.
  - CTRL bits 7:1 read 0.
- Undefined:
  - BASE_ADDR+2 is unmapped (no bus drive, writes ignored).
  - RX always uses i_rx.

Decomposition:
- Shared package io_uart_pkg:
  - Register offsets: DATA=0, STATUS=1, CTRL=2.
  - STATUS bit indices.
  - TX and RX FSM state enums.
- One sub-module: io_uart_fifo (synchronous FIFO, parameterised width/depth, push/pop/full/empty).
- Serializer, deserializer and decode stay in io_uart.

Test Plan:
- CLKS_PER_BIT=4; write 8'hA5 to 8'h10 -> o_tx low from cycle 2 for 4 cycles; then bits 1,0,1,0,0,1,0,1, 4 cycles each; then high. STATUS bit1 (txEmpty)=1 after the stop bit.
- Five back-to-back DATA writes with DEPTH=4 while TX is idle -> first is popped; next four fill the FIFO. STATUS=8'h01 (txFull) after the writes. All 5 bytes are transmitted with no idle gaps.
- Drive 8'h3C serially on i_rx -> STATUS reads 8'h06. DATA read returns 8'h3C. Next STATUS read returns 8'h02.
- Two RX frames without a DATA read -> DATA returns the first byte; STATUS bit3=1. After the STATUS read, bit3=0.
- RX frame with stop bit=0 -> rxValid=0, STATUS bit4=1. A 1-cycle low glitch on i_rx produces no byte.
- Assert i_reset mid-TX-frame -> o_tx=1 immediately; STATUS=8'h02 after release. With IO_UART_LOOPBACK_EN, write CTRL=1 then DATA=8'h5A -> DATA read returns 8'h5A.
